// File: rtl/accum_resv_pipe.sv
// accum_resv_pipe: two-stage column accumulation-reservation pipeline.
// Stage 1 realigns each digit's high slice into the next column and compresses
// five operands per column into a registered carry-save pair. Stage 2 either
// re-registers that pair or, with ACCUM_RESV_FEEDBACK_EN defined, folds it into
// a carry-save accumulator spanning a first..last group of beats.
// Valid/ready handshake on both sides; spill_nz flags a non-zero top high slice.
module accum_resv_pipe #(
    parameter int unsigned NUM_DIGITS = 130,
    parameter int unsigned IN_W       = 23,
    parameter int unsigned SPLIT      = 8,
    parameter int unsigned SHIFT      = 8,
    parameter int unsigned ADD2_W     = 17,
    parameter int unsigned OUT_W      = 19
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic [NUM_DIGITS*IN_W-1:0]   adder1_c,
    input  logic [NUM_DIGITS*IN_W-1:0]   adder1_s,
    input  logic [NUM_DIGITS*ADD2_W-1:0] adder2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_DIGITS*OUT_W-1:0]  out_c,
    output logic [NUM_DIGITS*OUT_W-1:0]  out_s,
    output logic                         spill_nz
);
    localparam int unsigned HI_W = IN_W - SPLIT;
    localparam int unsigned IN_T = NUM_DIGITS * IN_W;

    // Carry word weight 2 -> shift by one column bit, MSB carry dropped (mod 2^OUT_W).
    function automatic logic [OUT_W-1:0] shl1(input logic [OUT_W-1:0] v);
        return {v[OUT_W-2:0], 1'b0};
    endfunction

    // 3:2 counter returning {raw carry (weight 2), sum}.
    function automatic logic [2*OUT_W-1:0] csa3(input logic [OUT_W-1:0] x,
                                                input logic [OUT_W-1:0] y,
                                                input logic [OUT_W-1:0] z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    // 5:2 tree of three chained 3:2 counters; final carry left unshifted.
    function automatic logic [2*OUT_W-1:0] csa5(input logic [OUT_W-1:0] a,
                                                input logic [OUT_W-1:0] b,
                                                input logic [OUT_W-1:0] c,
                                                input logic [OUT_W-1:0] d,
                                                input logic [OUT_W-1:0] e);
        logic [2*OUT_W-1:0] t;
        t = csa3(a, b, c);
        t = csa3(t[OUT_W-1:0], shl1(t[2*OUT_W-1:OUT_W]), d);
        t = csa3(t[OUT_W-1:0], shl1(t[2*OUT_W-1:OUT_W]), e);
        return t;
    endfunction

`ifdef ACCUM_RESV_FEEDBACK_EN
    // 4:2 compressor returning {weighted carry, sum}.
    function automatic logic [2*OUT_W-1:0] csa4(input logic [OUT_W-1:0] a,
                                                input logic [OUT_W-1:0] b,
                                                input logic [OUT_W-1:0] c,
                                                input logic [OUT_W-1:0] d);
        logic [2*OUT_W-1:0] t;
        t = csa3(a, b, c);
        t = csa3(t[OUT_W-1:0], shl1(t[2*OUT_W-1:OUT_W]), d);
        return {shl1(t[2*OUT_W-1:OUT_W]), t[OUT_W-1:0]};
    endfunction
`endif

    // Handshake
    logic w_s2_free;

    // Stage 1 combinational operands / results
    logic [NUM_DIGITS-1:0][OUT_W-1:0] w_hs;
    logic [NUM_DIGITS-1:0][OUT_W-1:0] w_hc;
    logic [NUM_DIGITS-1:0][OUT_W-1:0] w_c1;
    logic [NUM_DIGITS-1:0][OUT_W-1:0] w_s1;
    logic                             w_spill1;

    // Stage 1 registers
    logic                             r_s1_valid;
    logic [NUM_DIGITS-1:0][OUT_W-1:0] r_c1;
    logic [NUM_DIGITS-1:0][OUT_W-1:0] r_s1;
    logic                             r_s1_spill;

    // Stage 2 next values and registers
    logic [NUM_DIGITS-1:0][OUT_W-1:0] w_n_c;
    logic [NUM_DIGITS-1:0][OUT_W-1:0] w_n_s;
    logic                             r_out_valid;
    logic [NUM_DIGITS-1:0][OUT_W-1:0] r_out_c;
    logic [NUM_DIGITS-1:0][OUT_W-1:0] r_out_s;
    logic                             r_spill;

`ifdef ACCUM_RESV_FEEDBACK_EN
    logic                             r_s1_first;
    logic                             r_s1_last;
    logic                             r_grp_open;
    logic                             w_clr;
    logic [NUM_DIGITS-1:0][OUT_W-1:0] w_acc_c;
    logic [NUM_DIGITS-1:0][OUT_W-1:0] w_acc_s;

    // Accumulator restarts on in_first, after reset and after a closing beat.
    assign w_clr   = r_s1_first || !r_grp_open;
    assign w_acc_c = w_clr ? '0 : r_out_c;
    assign w_acc_s = w_clr ? '0 : r_out_s;
`else
    logic w_unused_flags;
    assign w_unused_flags = in_first ^ in_last;
`endif

    assign w_s2_free = !r_out_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_free;
    assign out_valid = r_out_valid;
    assign out_c     = r_out_c;
    assign out_s     = r_out_s;
    assign spill_nz  = r_spill && r_out_valid;

    assign w_spill1 = (|adder1_s[IN_T-1 -: HI_W]) | (|adder1_c[IN_T-1 -: HI_W]);

    // Realign high slices into the next column and compress five operands per column.
    always_comb begin
        w_hs = '0;
        w_hc = '0;
        w_c1 = '0;
        w_s1 = '0;
        for (int unsigned m = 1; m < NUM_DIGITS; m++) begin
            w_hs[m] = OUT_W'(adder1_s[(m-1)*IN_W+SPLIT +: HI_W]);
            w_hc[m] = OUT_W'(adder1_c[(m-1)*IN_W+SPLIT +: HI_W]);
        end
        for (int unsigned m = 0; m < NUM_DIGITS; m++) begin
            {w_c1[m], w_s1[m]} = csa5(OUT_W'(adder1_s[m*IN_W +: SPLIT]) << SHIFT,
                                      OUT_W'(adder1_c[m*IN_W +: SPLIT]) << SHIFT,
                                      w_hs[m],
                                      w_hc[m],
                                      OUT_W'(adder2[m*ADD2_W +: ADD2_W]));
        end
    end

    // Stage-2 next value: plain re-registration or fold into the accumulator.
    always_comb begin
        w_n_c = '0;
        w_n_s = '0;
        for (int unsigned m = 0; m < NUM_DIGITS; m++) begin
`ifdef ACCUM_RESV_FEEDBACK_EN
            {w_n_c[m], w_n_s[m]} = csa4(shl1(r_c1[m]), r_s1[m], w_acc_c[m], w_acc_s[m]);
`else
            w_n_c[m] = shl1(r_c1[m]);
            w_n_s[m] = r_s1[m];
`endif
        end
    end

    // Stage 1 register: load on accept, hold while stage 2 is blocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_c1       <= '0;
            r_s1       <= '0;
            r_s1_spill <= 1'b0;
`ifdef ACCUM_RESV_FEEDBACK_EN
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
`endif
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_c1       <= w_c1;
                r_s1       <= w_s1;
                r_s1_spill <= w_spill1;
`ifdef ACCUM_RESV_FEEDBACK_EN
                r_s1_first <= in_first;
                r_s1_last  <= in_last;
`endif
            end
        end
    end

    // Stage 2 / output register: advance when free, hold while out_valid && !out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_c     <= '0;
            r_out_s     <= '0;
            r_spill     <= 1'b0;
`ifdef ACCUM_RESV_FEEDBACK_EN
            r_grp_open  <= 1'b0;
`endif
        end else if (w_s2_free) begin
`ifdef ACCUM_RESV_FEEDBACK_EN
            r_out_valid <= r_s1_valid && r_s1_last;
            if (r_s1_valid) begin
                r_out_c    <= w_n_c;
                r_out_s    <= w_n_s;
                r_spill    <= r_s1_spill | (r_spill & !w_clr);
                r_grp_open <= !r_s1_last;
            end
`else
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_c <= w_n_c;
                r_out_s <= w_n_s;
                r_spill <= r_s1_spill;
            end
`endif
        end
    end

endmodule

// File: tb/tb_accum_resv_pipe.sv
// Self-checking bench for accum_resv_pipe. Expected column sums come from plain
// per-column arithmetic on the digit values; results are queued in acceptance
// order (grouped first..last when ACCUM_RESV_FEEDBACK_EN is defined).
module tb_accum_resv_pipe;
    localparam int unsigned ND  = 130;
    localparam int unsigned IW  = 23;
    localparam int unsigned SPL = 8;
    localparam int unsigned SHF = 8;
    localparam int unsigned AW  = 17;
    localparam int unsigned OW  = 19;
    localparam int unsigned NIN = ND * IW;
    localparam int unsigned NA  = ND * AW;
    localparam int unsigned NO  = ND * OW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           in_first = 1'b0;
    logic           in_last = 1'b0;
    logic [NIN-1:0] adder1_c = '0;
    logic [NIN-1:0] adder1_s = '0;
    logic [NA-1:0]  adder2 = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [NO-1:0]  out_c;
    logic [NO-1:0]  out_s;
    logic           spill_nz;

    int             checks = 0;
    int             failures = 0;
    logic [NO-1:0]  exp_q[$];
    bit             exp_spill_q[$];
    logic [NO-1:0]  acc_m = '0;
    bit             acc_spill = 1'b0;
    bit             grp_open = 1'b0;
    logic [NO-1:0]  snap_c;
    logic [NO-1:0]  snap_s;
    logic           snap_sp;
    bit             acc_now;

    always #5 clk = ~clk;

    accum_resv_pipe #(
        .NUM_DIGITS (ND),
        .IN_W       (IW),
        .SPLIT      (SPL),
        .SHIFT      (SHF),
        .ADD2_W     (AW),
        .OUT_W      (OW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .adder1_c  (adder1_c),
        .adder1_s  (adder1_s),
        .adder2    (adder2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_s     (out_s),
        .spill_nz  (spill_nz)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Column m sum = (lowS+lowC)*2^SHF + highS[m-1] + highC[m-1] + adder2[m], mod 2^OW.
    function automatic logic [NO-1:0] beat_sums(input logic [NIN-1:0] s, input logic [NIN-1:0] c,
                                                input logic [NA-1:0] a);
        logic [NO-1:0] r;
        int unsigned   v;
        r = '0;
        for (int unsigned m = 0; m < ND; m++) begin
            v = (32'(s[m*IW +: IW]) % (1 << SPL) + 32'(c[m*IW +: IW]) % (1 << SPL)) * (1 << SHF)
                + 32'(a[m*AW +: AW]);
            if (m > 0)
                v = v + 32'(s[(m-1)*IW +: IW]) / (1 << SPL) + 32'(c[(m-1)*IW +: IW]) / (1 << SPL);
            r[m*OW +: OW] = OW'(v);
        end
        return r;
    endfunction

    function automatic logic [NO-1:0] add_cols(input logic [NO-1:0] x, input logic [NO-1:0] y);
        logic [NO-1:0] r;
        r = '0;
        for (int unsigned m = 0; m < ND; m++)
            r[m*OW +: OW] = OW'(32'(x[m*OW +: OW]) + 32'(y[m*OW +: OW]));
        return r;
    endfunction

    function automatic logic [OW-1:0] dut_col(input int unsigned m);
        return out_c[m*OW +: OW] + out_s[m*OW +: OW];
    endfunction

    task automatic model_accept();
        logic [NO-1:0] b;
        bit            sp;
        b  = beat_sums(adder1_s, adder1_c, adder2);
        sp = ((adder1_s[NIN-1 -: IW] >> SPL) != 0) || ((adder1_c[NIN-1 -: IW] >> SPL) != 0);
`ifdef ACCUM_RESV_FEEDBACK_EN
        if (in_first || !grp_open) begin
            acc_m     = '0;
            acc_spill = 1'b0;
        end
        acc_m     = add_cols(acc_m, b);
        acc_spill = acc_spill | sp;
        if (in_last) begin
            exp_q.push_back(acc_m);
            exp_spill_q.push_back(acc_spill);
            grp_open = 1'b0;
        end else begin
            grp_open = 1'b1;
        end
`else
        exp_q.push_back(b);
        exp_spill_q.push_back(sp);
`endif
    endtask

    task automatic check_pop();
        logic [NO-1:0] e;
        bit            sp;
        int unsigned   bad;
        check("pop_has_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() == 0) return;
        e   = exp_q.pop_front();
        sp  = exp_spill_q.pop_front();
        bad = 0;
        for (int unsigned m = 0; m < ND; m++) begin
            if (dut_col(m) !== e[m*OW +: OW]) begin
                bad = m;
                break;
            end
        end
        check($sformatf("pop_col%0d_sum", bad), 64'(dut_col(bad)), 64'(e[bad*OW +: OW]));
        check("pop_spill", 64'(spill_nz), 64'(sp));
    endtask

    // Settle, account for the handshakes of this cycle, advance one clock.
    task automatic tick();
        #1;
        if (out_valid && out_ready) check_pop();
        if (in_valid && in_ready) model_accept();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_beat();
        for (int unsigned m = 0; m < ND; m++) begin
            adder1_s[m*IW +: IW] = IW'($urandom);
            adder1_c[m*IW +: IW] = IW'($urandom);
            adder2[m*AW +: AW]   = AW'($urandom);
        end
    endtask

    task automatic fill_beat(input logic [IW-1:0] sd, input logic [IW-1:0] cd, input logic [AW-1:0] ad);
        for (int unsigned m = 0; m < ND; m++) begin
            adder1_s[m*IW +: IW] = sd;
            adder1_c[m*IW +: IW] = cd;
            adder2[m*AW +: AW]   = ad;
        end
    endtask

    // Single-beat groups with feedback; random (ignored) flags without it.
    task automatic std_flags();
`ifdef ACCUM_RESV_FEEDBACK_EN
        in_first = 1'b1;
        in_last  = 1'b1;
`else
        in_first = 1'($urandom);
        in_last  = 1'($urandom);
`endif
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("drain_queue_empty", 64'(exp_q.size()), 0);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_c_ones", 64'($countones(out_c)), 0);
        check("rst_out_s_ones", 64'($countones(out_s)), 0);
        check("rst_spill", 64'(spill_nz), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 64'(in_ready), 1);

        // Directed beat: digits 0x1FF, adder2 = 1
        out_ready = 1'b1;
        fill_beat(23'h1FF, 23'h1FF, 17'h1);
        in_first = 1'b1;
        in_last  = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat_plus1_out_valid", 64'(out_valid), 0);
        tick();
        check("lat_plus2_out_valid", 64'(out_valid), 1);
        check("dir_col0", 64'(dut_col(0)), 64'h1FE01);
        check("dir_col1", 64'(dut_col(1)), 64'h1FE03);
        check("dir_col129", 64'(dut_col(ND-1)), 64'h1FE03);
        check("dir_spill", 64'(spill_nz), 1);
        tick();
        check("dir_single_output", 64'(out_valid), 0);
        drain();

        // Back-to-back 8 beats, out_ready held high
        for (int i = 0; i < 12; i++) begin
            if (i < 8) begin
                rand_beat();
                std_flags();
                in_valid = 1'b1;
                check($sformatf("b2b%0d_in_ready", i), 64'(in_ready), 1);
            end else begin
                in_valid = 1'b0;
            end
            check($sformatf("b2b%0d_out_valid", i), 64'(out_valid), (i >= 2 && i < 10) ? 1 : 0);
            tick();
        end
        drain();

        // Output stall for 5 cycles while input keeps offering
        out_ready = 1'b0;
        rand_beat();
        std_flags();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d_in_ready", i), 64'(in_ready), (i < 2) ? 1 : 0);
            check($sformatf("stall%0d_out_valid", i), 64'(out_valid), (i >= 2) ? 1 : 0);
            if (i == 2) begin
                snap_c  = out_c;
                snap_s  = out_s;
                snap_sp = spill_nz;
            end else if (i > 2) begin
                check($sformatf("stall%0d_c_stable", i), 64'($countones(out_c ^ snap_c)), 0);
                check($sformatf("stall%0d_s_stable", i), 64'($countones(out_s ^ snap_s)), 0);
                check($sformatf("stall%0d_spill_stable", i), 64'(spill_nz), 64'(snap_sp));
            end
            acc_now = in_ready;
            tick();
            if (acc_now) begin
                rand_beat();
                std_flags();
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            acc_now = in_ready;
            tick();
            if (acc_now) begin
                rand_beat();
                std_flags();
            end
        end
        drain();

        // Reset with two beats in flight
        rand_beat();
        std_flags();
        in_valid = 1'b1;
        tick();
        rand_beat();
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 0);
        check("midrst_out_c_ones", 64'($countones(out_c)), 0);
        check("midrst_out_s_ones", 64'($countones(out_s)), 0);
        check("midrst_spill", 64'(spill_nz), 0);
        exp_q.delete();
        exp_spill_q.delete();
        grp_open = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rand_beat();
        std_flags();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("postrst_plus1_out_valid", 64'(out_valid), 0);
        tick();
        check("postrst_plus2_out_valid", 64'(out_valid), 1);
        tick();
        check("postrst_alone", 64'(out_valid), 0);
        drain();

`ifdef ACCUM_RESV_FEEDBACK_EN
        // Three-beat group, only adder2[5] = 0x10
        fill_beat('0, '0, '0);
        adder2[5*AW +: AW] = 17'h10;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_first = (i == 0);
            in_last  = (i == 2);
            check($sformatf("grp%0d_out_valid", i), 64'(out_valid), 0);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("grp_out_valid", 64'(out_valid), 1);
        check("grp_col5", 64'(dut_col(5)), 64'h30);
        check("grp_col4", 64'(dut_col(4)), 0);
        tick();
        // Next beat without in_first starts a fresh sum
        in_first = 1'b0;
        in_last  = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("fresh_out_valid", 64'(out_valid), 1);
        check("fresh_col5", 64'(dut_col(5)), 64'h10);
        drain();
`endif

        // Randomised traffic with random backpressure
        rand_beat();
        for (int i = 0; i < 60; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
`ifdef ACCUM_RESV_FEEDBACK_EN
            in_first = ($urandom_range(3) == 0);
            in_last  = ($urandom_range(2) == 0);
`else
            in_first = 1'($urandom);
            in_last  = 1'($urandom);
`endif
            acc_now = in_valid && in_ready;
            tick();
            if (acc_now) rand_beat();
        end
        drain();
        check("final_out_valid", 64'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/accum_resv_pipe.md
# accum_resv_pipe

Parametrised, pipelined successor of the column accumulation-reservation stage in the modular squaring datapath. Each accepted beat carries a per-digit carry-save pair (Adder1 C/S) and a per-digit side operand (Adder2). The block realigns each digit's high slice into the next digit column and compresses five operands per column to a registered carry-save pair. It adds a valid/ready handshake and overflow detection on the top digit. A compile-time option accumulates several beats into one result.

## Interface
- NUM_DIGITS, 130: number of digit columns.
- IN_W, 23: width of each Adder1 C/S digit.
- SPLIT, 8: low-slice width kept in its own column; placed at bit offset SHIFT.
- SHIFT, 8: left offset of the low slice within the column.
- ADD2_W, 17: width of each Adder2 digit.
- OUT_W, 19: width of each output C/S digit; all column arithmetic is modulo 2^OUT_W.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat offered.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_first  in  1  starts a new accumulation group (used only with the feedback option).
- in_last  in  1  closes the group (used only with the feedback option).
- adder1_c, adder1_s  in  NUM_DIGITS*IN_W  carry-save input digits.
- adder2  in  NUM_DIGITS*ADD2_W  side operand digits.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_c, out_s  out  NUM_DIGITS*OUT_W  carry-save result digits.
- spill_nz  out  1  top-digit high slice was non-zero in some beat of this result.

## Operation
- Column m operands: S[m][SPLIT-1:0]<<SHIFT, C[m][SPLIT-1:0]<<SHIFT, S[m-1][IN_W-1:SPLIT], C[m-1][IN_W-1:SPLIT], adder2[m]. All operands are zero-extended to OUT_W. For m=0 the two m-1 operands are zero.
- Stage 1 (registered): a per-column 5:2 CSA tree produces (c1,s1). It also registers spill1 = |{S[NUM_DIGITS-1][IN_W-1:SPLIT], C[NUM_DIGITS-1][IN_W-1:SPLIT]}.
- Stage 2 (registered): out_c/out_s are driven from the stage-2 registers. Without the feedback option, stage 2 is c1/s1 re-registered, with the 1-bit column carry shifted into bit 0 of the C word and the MSB carry discarded.
- Invariant: for every column, out_c+out_s ≡ sum of the five operands (mod 2^OUT_W).
- Pipeline control: s2_free = !out_valid || out_ready; s1 advances when s2_free; in_ready = !s1_valid || s2_free. A stalled stage holds its data and flags unchanged.
- Throughput is one beat per cycle when out_ready is held high.
- spill_nz is registered with the data and valid only while out_valid is high.

## Timing
- Reset (asynchronous): s1_valid=0, out_valid=0, out_c=0, out_s=0, spill_nz=0, accumulator cleared. in_ready=1 from the first edge after reset deassertion.
- Latency: a beat accepted at edge t appears in s1 at edge t+1 and on out_* at edge t+2.
- out_c, out_s and spill_nz are stable while out_valid && !out_ready.
- Simultaneous events: an output pop and an input accept in the same cycle are both honoured with no bubble.
- Reset mid-operation discards all in-flight beats and any partial group. No output is produced for them.

## Configuration
- ACCUM_RESV_FEEDBACK_EN defined: stage 2 is a 4:2 compressor of (c1,s1,acc_c,acc_s) into acc_c/acc_s, and out_c/out_s = acc_c/acc_s.
  - acc operands are forced to zero for a beat with in_first, for the first beat after reset, and for the first beat after a last beat.
  - A non-last beat updates the accumulator without raising out_valid.
  - A last beat raises out_valid; the accumulator holds until popped.
  - in_first and in_last may both be set on one beat, giving a single-beat group.
  - in_first in mid-group discards the partial sum.
  - spill_nz is the OR of spill1 over the whole group.
  - Overflow beyond 2^OUT_W is the caller's responsibility.
- ACCUM_RESV_FEEDBACK_EN undefined: in_first and in_last are ignored, and every accepted beat yields one output 2 cycles later.

## Test plan
- Single beat with all S/C digits = 23'h1FF, adder2 = 17'h1, NUM_DIGITS=130 -> after 2 cycles, each column m≥1 satisfies out_c+out_s = 2·(0xFF<<8)+2·0x1+1 = 0x1FE03; column 0 = 0x1FE01; spill_nz=1.
- Back-to-back 8 beats with out_ready=1 -> 8 out_valid cycles contiguous, in_ready never drops, results in order.
- out_ready=0 for 5 cycles during streaming -> in_ready falls after two beats are buffered; no beat is lost or duplicated; out_* stays stable.
- Assert rst_n low while 2 beats are in flight -> out_valid=0 immediately and all outputs 0; the next beat after release appears alone at +2.
- With FEEDBACK_EN: 3 beats (first, -, last) each with only adder2[5]=17'h10 -> one output with column 5 summing to 0x30 and all others 0; the next beat without in_first starts a fresh sum.
- With FEEDBACK_EN: a beat with in_first and in_last together -> output equals the no-feedback result for that beat.
